// File: rtl/mem_bist_engine.sv
// mem_bist_engine: writes a pattern to every memory word, reads it back pipelined and checks each word
module mem_bist_engine #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  localparam logic [DATA_WIDTH-1:0] CB = DATA_WIDTH'({DATA_WIDTH{2'b01}});
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, ffa_q, ffa_d;
  logic [DATA_WIDTH-1:0] ffd_q, ffd_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [2:0] drain_q, drain_d;
  logic [1:0] mode_q, mode_d;
  logic pass_q, pass_d, mis;
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] pa_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pd_q;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] av;
    av = DATA_WIDTH'(a);
    return m == 2'd0 ? '0 : m == 2'd1 ? av : m == 2'd2 ? (a[0] ? ~CB : CB) : ~av;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    drain_d = drain_q;
    mode_d = mode_q;
    err_d = err_q;
    ffa_d = ffa_q;
    ffd_d = ffd_q;
    pass_d = pass_q;
    read = 1'b0;
    write = 1'b0;
    addr = '0;
    data_in = '0;
    busy = state_q == WRITE || state_q == READ || state_q == DRAIN;
    done = state_q == DONE;
    mis = vld_q[READ_LATENCY-1] && data_out != pd_q[READ_LATENCY-1];
    if (mis) begin
      err_d = err_q == '1 ? err_q : err_q + 1'b1;
      ffa_d = err_q == '0 ? pa_q[READ_LATENCY-1] : ffa_q;
      ffd_d = err_q == '0 ? data_out : ffd_q;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = WRITE;
        mode_d = mode;
        cnt_d = '0;
        err_d = '0;
        ffa_d = '0;
        ffd_d = '0;
        pass_d = 1'b0;
      end
      WRITE: begin
        write = 1'b1;
        addr = cnt_q;
        data_in = pat(mode_q, cnt_q);
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == '1 ? READ : WRITE;
      end
      READ: begin
        read = 1'b1;
        addr = cnt_q;
        cnt_d = cnt_q + 1'b1;
        drain_d = '0;
        state_d = cnt_q == '1 ? DRAIN : READ;
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 3'(READ_LATENCY - 1)) begin
          state_d = DONE;
          pass_d = err_d == '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // expected-data pipeline: an entry pushed on a read cycle matures READ_LATENCY cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      drain_q <= '0;
      mode_q <= '0;
      err_q <= '0;
      ffa_q <= '0;
      ffd_q <= '0;
      pass_q <= 1'b0;
      vld_q <= '0;
      pa_q <= '0;
      pd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      mode_q <= mode_d;
      err_q <= err_d;
      ffa_q <= ffa_d;
      ffd_q <= ffd_d;
      pass_q <= pass_d;
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      vld_q[0] <= read;
      pa_q[0] <= addr;
      pd_q[0] <= pat(mode_q, addr);
    end
  end

  assign pass = pass_q;
  assign err_count = err_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_data = ffd_q;
endmodule

// File: tb/tb_mem_bist_engine.sv
// tb_mem_bist_engine: three engine instances (default with fault-injectable memory, ERR_WIDTH=3 on a
// stuck bus, READ_LATENCY=3) driven by directed runs whose expected results come from a scoreboard queue
module tb_mem_bist_engine;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] mode = 2'd0;
  logic [2:0] st = '0;
  int sel = 0, checks = 0, errors = 0;
  logic f_stuck = 1'b0, f_short = 1'b0;

  logic b0, d0, p0, r0, w0, b1, d1, p1, r1, w1, b2, d2, p2, r2, w2;
  logic [15:0] e0, e2;
  logic [2:0] e1;
  logic [4:0] fa0, fa1, fa2, a0, a1, a2;
  logic [7:0] fd0, fd1, fd2, di0, di1, di2, do0, do2;
  logic [7:0] do1 = 8'hFF;

  mem_bist_engine dut0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .mode(mode), .busy(b0), .done(d0),
    .pass(p0), .err_count(e0), .first_fail_addr(fa0), .first_fail_data(fd0), .read(r0), .write(w0),
    .addr(a0), .data_in(di0), .data_out(do0));
  mem_bist_engine #(.ERR_WIDTH(3)) dut1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .mode(mode), .busy(b1),
    .done(d1), .pass(p1), .err_count(e1), .first_fail_addr(fa1), .first_fail_data(fd1), .read(r1),
    .write(w1), .addr(a1), .data_in(di1), .data_out(do1));
  mem_bist_engine #(.READ_LATENCY(3)) dut2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .mode(mode), .busy(b2),
    .done(d2), .pass(p2), .err_count(e2), .first_fail_addr(fa2), .first_fail_data(fd2), .read(r2),
    .write(w2), .addr(a2), .data_in(di2), .data_out(do2));

  // memory models: dut0 with optional stuck bit / shorted cells, dut2 with a 3-cycle read pipe
  logic [7:0] mem0 [32];
  logic [7:0] mem2 [32];
  logic [7:0] dq2 [3];
  always @(posedge clk) begin
    if (w0) begin
      if (f_short && (a0 == 5'd3 || a0 == 5'd4)) begin
        mem0[3] <= di0;
        mem0[4] <= di0;
      end else mem0[a0] <= (f_stuck && a0 == 5'd12) ? (di0 & ~8'h04) : di0;
    end
    if (r0) do0 <= mem0[a0];
    if (w2) mem2[a2] <= di2;
    dq2[0] <= mem2[a2];
    dq2[1] <= dq2[0];
    dq2[2] <= dq2[1];
  end
  assign do2 = dq2[2];

  logic m_done, m_busy, m_rd, m_wr, m_pass;
  logic [15:0] m_err;
  logic [4:0] m_ffa;
  logic [7:0] m_ffd;
  always_comb begin
    {m_done, m_busy, m_rd, m_wr, m_pass, m_err, m_ffa, m_ffd} = {b0, d0 & 1'b0, r0, w0, p0, e0, fa0, fd0};
    m_done = d0;
    m_busy = b0;
    if (sel == 1) {m_done, m_busy, m_rd, m_wr, m_pass, m_err, m_ffa, m_ffd} = {d1, b1, r1, w1, p1, 16'(e1), fa1, fd1};
    if (sel == 2) {m_done, m_busy, m_rd, m_wr, m_pass, m_err, m_ffa, m_ffd} = {d2, b2, r2, w2, p2, e2, fa2, fd2};
  end

  typedef struct {string tag; int cyc; logic ps; int er; int fa; int fd;} exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input int s, input logic [1:0] m, input string tag, input int cyc,
                      input logic ps, input int er, input int fa, input int fd);
    sb.push_back('{tag, cyc, ps, er, fa, fd});
    sel = s;
    mode = m;
    @(negedge clk);
    st[s] = 1'b1;
    @(posedge clk);
    #1;
    st = '0;
  endtask

  // called in cycle 1 of a run; follows it to done and compares against the scoreboard head
  task automatic wait_done(input int ignore_at);
    exp_t e;
    int n = 1, ov = 0;
    bit seen = 0;
    e = sb.pop_front();
    chk({e.tag, "_busy1"}, m_busy, 1'b1);
    chk({e.tag, "_clr"}, {m_pass, m_err}, 17'd0);
    while (n < 200 && !seen) begin
      if (m_rd && m_wr) ov++;
      st = '0;
      if (n == ignore_at) st[sel] = 1'b1;
      if (m_done) seen = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    st = '0;
    chk({e.tag, "_cycle"}, seen ? n : 0, e.cyc);
    chk({e.tag, "_rdwr"}, ov, 0);
    chk({e.tag, "_busy_done"}, m_busy, 1'b0);
    chk({e.tag, "_pass"}, m_pass, e.ps);
    chk({e.tag, "_err"}, m_err, e.er);
    chk({e.tag, "_ffa"}, m_ffa, e.fa);
    chk({e.tag, "_ffd"}, m_ffd, e.fd);
    @(posedge clk);
    #1;
    chk({e.tag, "_done_1cyc"}, m_done, 1'b0);
  endtask

  initial begin
    int dn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {b0, d0, p0, r0, w0, a0, di0, e0, fa0, fd0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(0, 2'd0, "m0", 66, 1'b1, 0, 0, 0);
    wait_done(0);
    f_stuck = 1'b1;
    kick(0, 2'd1, "m1stuck", 66, 1'b0, 1, 12, 8'h08);
    wait_done(0);
    f_stuck = 1'b0;
    f_short = 1'b1;
    kick(0, 2'd2, "m2short", 66, 1'b0, 1, 3, 8'h55);
    wait_done(0);
    kick(0, 2'd3, "m3short", 66, 1'b0, 1, 3, 8'hFB);
    wait_done(0);
    f_short = 1'b0;
    kick(1, 2'd0, "sat", 66, 1'b0, 7, 0, 8'hFF);
    wait_done(0);
    kick(2, 2'd1, "lat3", 68, 1'b1, 0, 0, 0);
    wait_done(20);
    sel = 0;
    mode = 2'd1;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st = '0;
    repeat (39) @(posedge clk);
    #2;
    chk("busy_before_rst", b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {b0, d0, p0, r0, w0, a0, di0, e0, fa0, fd0}, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      if (d0) dn++;
    end
    chk("rst_no_done", dn, 0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(0, 2'd1, "after_rst", 66, 1'b1, 0, 0, 0);
    wait_done(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
